uart_tx: RTL and testbench

//   Serial UART transmitter, 8N1 by default: the transmit-side counterpart of the board's receive path.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 90 +++++++++
 rtl/uart_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_tx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and helpers for the UART transmit path.
//   - tx_state_t      : transmitter FSM state encoding
//   - clks_per_bit()  : integer-truncated clocks per bit from clock and baud
//   - UART_IDLE_LEVEL : level of the serial line when no frame is in flight
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous single-clock FIFO buffering bytes ahead of the serialiser.
//   The head entry is presented on rdata combinationally (no read latency).
//   Pointers wrap modulo DEPTH; the occupancy count tells full from empty.
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous reset, active-high (clears pointers and level)
//   push   in   write wdata; ignored while full
//   wdata  in   byte to store
//   pop    in   discard the head entry; ignored while empty
//   rdata  out  head entry
//   full   out  no free slot
//   empty  out  no stored entry
//   level  out  number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: the storage array has no reset; only the pointers and level need
    // one, because an entry is never read before it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter, 8N1 by default. Bytes arrive over a valid/ready
//   handshake, are buffered in uart_tx_fifo and shifted out LSB-first on tx.
//   Frames are sent back to back when the FIFO holds more data at the end of
//   a stop bit.
//
//   Optional feature: define UART_TX_PARITY_EN to insert a parity bit after
//   the data bits (parameter PARITY_ODD: 0 = even, 1 = odd parity).
//
// Ports
//   clk       in   system clock
//   rst       in   synchronous reset, active-high; abandons any frame
//   tx_data   in   byte to transmit, captured at acceptance
//   tx_valid  in   tx_data is valid this cycle
//   tx_ready  out  FIFO can accept a byte (not full)
//   tx        out  serial line, registered, idles high
//   busy      out  frame in progress or FIFO not empty
//   level     out  current FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int FIFO_DEPTH   = 8,
    parameter int STOP_BITS    = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter int PARITY_ODD   = 0
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    tx_state_t   state_q;
    logic [CW-1:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        tx_q;
`ifdef UART_TX_PARITY_EN
    logic        parity_q;
`endif

    logic [7:0]  fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        baud_wrap;
    logic        last_stop;
    logic        load_frame;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .wdata (tx_data),
        .pop   (load_frame),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign baud_wrap = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign last_stop = (bit_q == 3'(STOP_BITS - 1));

    // A new frame starts from IDLE, or directly at the end of the final stop
    // bit so consecutive frames have no idle gap.
    assign load_frame = !fifo_empty &&
                        ((state_q == IDLE) ||
                         (state_q == STOP && baud_wrap && last_stop));

    assign tx_ready = !fifo_full;
    assign tx       = tx_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (load_frame) begin
            state_q  <= START;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= fifo_rdata;
            tx_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= (^fifo_rdata) ^ 1'(PARITY_ODD);
`endif
        end else begin
            // Bit boundaries fall only on the baud wrap edge.
            baud_q <= baud_wrap ? '0 : baud_q + CW'(1);
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    tx_q   <= UART_IDLE_LEVEL;
                end
                START: begin
                    if (baud_wrap) begin
                        tx_q    <= shift_q[0];
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_q == 3'd7) begin
                            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= PARITY;
`else
                            tx_q    <= UART_IDLE_LEVEL;
                            state_q <= STOP;
`endif
                        end else begin
                            // Next bit is shift_q[1]; shift so it becomes bit 0.
                            tx_q    <= shift_q[1];
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_wrap) begin
                        tx_q    <= UART_IDLE_LEVEL;
                        bit_q   <= '0;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_wrap) begin
                        if (last_stop) begin
                            // FIFO empty here, otherwise load_frame took over.
                            state_q <= IDLE;
                            bit_q   <= '0;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= UART_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Two transmitters driven with the same byte stream: dut0 with one stop bit
//   (even parity when enabled), dut1 with two stop bits (odd parity when
//   enabled). A frame-schedule model predicts tx, busy, level and tx_ready
//   each cycle; a line decoder pops expected bytes from a scoreboard.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int HALF  = CPB / 2;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    function automatic int stop_bits(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic odd_par(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    function automatic int frame_len(input int i);
        return (1 + 8 + PAR + stop_bits(i)) * CPB;
    endfunction

    // Expected line level for bit slot k of a frame carrying d.
    function automatic logic bit_of(input logic [7:0] d, input int k, input int i);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PAR == 1 && k == 9) return (^d) ^ odd_par(i);
        return 1'b1;
    endfunction

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [1:0] tx_valid = 2'b00;
    logic [1:0] tx_ready;
    logic [1:0] tx_line;
    logic [1:0] busy;
    logic [3:0] lvl [2];

    always #5 clk = ~clk;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .STOP_BITS    (1)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD   (0)
`endif
    ) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid[0]),
        .tx_ready (tx_ready[0]),
        .tx       (tx_line[0]),
        .busy     (busy[0]),
        .level    (lvl[0])
    );

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .STOP_BITS    (2)
`ifdef UART_TX_PARITY_EN
        ,
        .PARITY_ODD   (1)
`endif
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid[1]),
        .tx_ready (tx_ready[1]),
        .tx       (tx_line[1]),
        .busy     (busy[1]),
        .level    (lvl[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit armed  = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model of scheduled frames: accepted at edge acc, first start-bit edge start.
    typedef struct {
        int         dut;
        logic [7:0] data;
        int         acc;
        int         start;
    } frame_t;

    typedef struct {
        int         dut;
        logic [7:0] data;
    } exp_t;

    frame_t frames[$];
    exp_t   sb[$];
    int     last_end [2];
    logic [1:0] rdy_s;
    logic [1:0] prev_tx;

    // tx_ready only moves on posedge, so the negedge copy is its pre-edge value.
    always @(negedge clk) rdy_s = tx_ready;

    task automatic check_dut(input int i);
        logic exp_tx;
        logic exp_busy;
        int   exp_lvl;
        logic on_bound;
        int   s;
        int   fl;
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
        exp_lvl  = 0;
        on_bound = 1'b0;
        fl       = frame_len(i);
        for (int j = 0; j < frames.size(); j++) begin
            if (frames[j].dut == i) begin
                s = frames[j].start;
                if (cyc < s) exp_lvl++;
                if (cyc < s + fl) exp_busy = 1'b1;
                if (cyc >= s && cyc < s + fl) exp_tx = bit_of(frames[j].data, (cyc - s) / CPB, i);
                if (cyc >= s && cyc <= s + fl && ((cyc - s) % CPB) == 0) on_bound = 1'b1;
            end
        end
        check($sformatf("dut%0d tx", i), tx_line[i], exp_tx);
        check($sformatf("dut%0d busy", i), busy[i], exp_busy);
        check($sformatf("dut%0d level", i), lvl[i], exp_lvl);
        check($sformatf("dut%0d tx_ready", i), tx_ready[i], (exp_lvl < DEPTH) ? 1 : 0);
        if (!rst && tx_line[i] !== prev_tx[i])
            check($sformatf("dut%0d tx change on baud wrap", i), on_bound, 1'b1);
        prev_tx[i] = tx_line[i];
    endtask

    always @(posedge clk) begin : model_p
        logic [1:0] acc;
        logic       r;
        logic [7:0] d;
        int         s;
        cyc++;
        acc = tx_valid & rdy_s;
        r   = rst;
        d   = tx_data;
        #1;
        if (r) begin
            armed = 1'b1;
            frames.delete();
            sb.delete();
            last_end[0] = 0;
            last_end[1] = 0;
        end else if (armed) begin
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    s = (cyc + 1 > last_end[i]) ? cyc + 1 : last_end[i];
                    frames.push_back('{dut: i, data: d, acc: cyc, start: s});
                    last_end[i] = s + frame_len(i);
                    sb.push_back('{dut: i, data: d});
                end
            end
        end
        if (armed) begin
            for (int i = 0; i < 2; i++) check_dut(i);
            for (int j = frames.size() - 1; j >= 0; j--) begin
                if (cyc > frames[j].start + frame_len(frames[j].dut)) frames.delete(j);
            end
        end
    end

    // Line decoder: samples bit centres and pops the scoreboard at the last stop bit.
    logic [1:0] dec_active = 2'b00;
    int         dec_cnt [2];
    logic [7:0] dec_byte [2];
    logic [1:0] dec_par;

    always @(posedge clk) begin : decoder_p
        int         k;
        bit         found;
        logic [7:0] exp_d;
        #1;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    dec_active[i] = 1'b0;
                end else if (!dec_active[i]) begin
                    if (tx_line[i] == 1'b0) begin
                        dec_active[i] = 1'b1;
                        dec_cnt[i]    = 0;
                    end
                end else begin
                    dec_cnt[i]++;
                    if (dec_cnt[i] >= HALF && ((dec_cnt[i] - HALF) % CPB) == 0) begin
                        k = (dec_cnt[i] - HALF) / CPB;
                        if (k == 0) begin
                            check($sformatf("dut%0d start bit", i), tx_line[i], 1'b0);
                        end else if (k <= 8) begin
                            dec_byte[i][k-1] = tx_line[i];
                        end else if (PAR == 1 && k == 9) begin
                            dec_par[i] = tx_line[i];
                        end else begin
                            check($sformatf("dut%0d stop bit", i), tx_line[i], 1'b1);
                            if (k == 8 + PAR + stop_bits(i)) begin
                                found = 1'b0;
                                exp_d = 8'h00;
                                for (int j = 0; j < sb.size(); j++) begin
                                    if (sb[j].dut == i) begin
                                        exp_d = sb[j].data;
                                        sb.delete(j);
                                        found = 1'b1;
                                        break;
                                    end
                                end
                                check($sformatf("dut%0d frame expected", i), found, 1'b1);
                                check($sformatf("dut%0d byte", i), dec_byte[i], exp_d);
`ifdef UART_TX_PARITY_EN
                                check($sformatf("dut%0d parity", i), dec_par[i], (^exp_d) ^ odd_par(i));
`endif
                                dec_active[i] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Offer one byte to both DUTs; each drops valid after its own acceptance edge.
    task automatic push_byte(input logic [7:0] b);
        int         budget;
        logic [1:0] a;
        budget   = 2000;
        tx_data  = b;
        tx_valid = 2'b11;
        while (tx_valid != 2'b00 && budget > 0) begin
            a = tx_valid & tx_ready;
            @(negedge clk);
            tx_valid = tx_valid & ~a;
            budget--;
        end
        if (budget == 0) begin
            check("push accepted", tx_valid, 2'b00);
            tx_valid = 2'b00;
        end
    endtask

    task automatic wait_idle(input int budget);
        while (busy != 2'b00 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("drain timeout busy", busy, 2'b00);
        repeat (3) @(negedge clk);
    endtask

    int exp_left [2];

    initial begin
        rst      = 1'b1;
        tx_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        push_byte(8'h55);
        wait_idle(400);

        for (int b = 0; b < 10; b++) push_byte(8'(b));
        wait_idle(3000);

        // Reset lands during data bit 3 (edge S+17 where S = acceptance+1).
        push_byte(8'hA3);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        push_byte(8'h52);
        wait_idle(400);

        push_byte(8'hFF);
        wait_idle(400);
        push_byte(8'h07);
        wait_idle(400);
        push_byte(8'h03);
        wait_idle(400);

        repeat (40) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
            push_byte(8'($urandom));
        end
        wait_idle(8000);

        exp_left[0] = 0;
        exp_left[1] = 0;
        foreach (sb[j]) exp_left[sb[j].dut]++;
        check("dut0 undelivered bytes", exp_left[0], 0);
        check("dut1 undelivered bytes", exp_left[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
